// File: rtl/tcu_ctrl_recv_slot_pkg.sv
// tcu_ctrl_recv_slot_pkg: shared TCU widths, register addresses, receive-EP field layout and error codes
package tcu_ctrl_recv_slot_pkg;
  localparam int TCU_REG_DATA_SIZE = 64;
  localparam int TCU_REG_ADDR_SIZE = 32;
  localparam int TCU_EP_SIZE       = 7;
  localparam int TCU_SLOT_SIZE     = 5;
  localparam int TCU_ERROR_SIZE    = 5;
  localparam logic [TCU_REG_ADDR_SIZE-1:0] TCU_REGADDR_CUR_VPE  = 32'h0000_0020;
  localparam logic [TCU_REG_ADDR_SIZE-1:0] TCU_REGADDR_EP_START = 32'h0000_0100;
  localparam logic [TCU_REG_ADDR_SIZE-1:0] TCU_EP_REG_SIZE      = 32'h0000_0018;
  typedef enum logic [2:0] {
    TCU_EP_INVALID = 3'd0,
    TCU_EP_SEND    = 3'd1,
    TCU_EP_RECEIVE = 3'd2,
    TCU_EP_MEMORY  = 3'd3
  } tcu_ep_type_e;
  localparam logic [TCU_ERROR_SIZE-1:0] TCU_ERROR_NONE               = 5'd0;
  localparam logic [TCU_ERROR_SIZE-1:0] TCU_ERROR_NO_REP             = 5'd4;
  localparam logic [TCU_ERROR_SIZE-1:0] TCU_ERROR_CRITICAL           = 5'd15;
  localparam logic [TCU_ERROR_SIZE-1:0] TCU_ERROR_RECV_OUT_OF_BOUNDS = 5'd18;
  localparam logic [TCU_ERROR_SIZE-1:0] TCU_ERROR_RECV_NO_SPACE      = 5'd19;
  // receive-EP word0 layout, shared with the fetch engine
  localparam int TCU_EP_TYPE_LSB     = 0;
  localparam int TCU_EP_VPE_LSB      = 3;
  localparam int TCU_EP_SLOTSIZE_LSB = 19;
  localparam int TCU_EP_SLOTS_LSB    = 25;
  localparam int TCU_EP_RPOS_LSB     = 30;
  localparam int TCU_EP_WPOS_LSB     = 35;
  localparam logic [TCU_REG_DATA_SIZE-1:0] TCU_EP_WPOS_MASK  = 64'h1F << TCU_EP_WPOS_LSB;
  localparam logic [TCU_REG_DATA_SIZE-1:0] TCU_CUR_VPE_MSGS_MASK = 64'h0000_0000_FFFF_0000;
  function automatic logic [5:0] max_slot(input logic [4:0] slots);
    return (slots > 5'd5) ? 6'd32 : 6'd1 << slots[2:0];
  endfunction
  function automatic logic [31:0] slot_mask(input logic [5:0] m);
    return m[5] ? '1 : (32'd1 << m[4:0]) - 32'd1;
  endfunction
endpackage

// File: rtl/tcu_ctrl_recv_slot.sv
// tcu_ctrl_recv_slot: allocates a receive slot for an incoming NoC message and writes back EP and CUR_VPE state
module tcu_ctrl_recv_slot
  import tcu_ctrl_recv_slot_pkg::*;
#(
  parameter bit TCU_ENABLE_VIRT_PES = 1'b0
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  output logic                           rs_reg_en_o,
  output logic [TCU_REG_DATA_SIZE-1:0]   rs_reg_wben_o,
  output logic [TCU_REG_ADDR_SIZE-1:0]   rs_reg_addr_o,
  output logic [TCU_REG_DATA_SIZE-1:0]   rs_reg_wdata_o,
  input  logic                           rs_reg_stall_i,
  input  logic                           rs_start_i,
  input  logic [TCU_EP_SIZE-1:0]         rs_recvep_i,
  input  logic [3*TCU_REG_DATA_SIZE-1:0] rs_epdata_i,
  input  logic [15:0]                    rs_msg_size_i,
  input  logic [31:0]                    rs_cur_vpe_i,
  output logic                           rs_active_o,
  output logic [TCU_REG_DATA_SIZE-1:0]   rs_msgaddr_o,
  output logic                           rs_done_o,
  output logic [TCU_ERROR_SIZE-1:0]      rs_error_o,
  input  logic                           tcu_features_virt_pes_i
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FIND   = 3'd1;
  localparam logic [2:0] S_WR_EP0 = 3'd2;
  localparam logic [2:0] S_WR_EP2 = 3'd3;
  localparam logic [2:0] S_WR_VPE = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;
  logic [2:0] state_q, state_d;
  logic [TCU_SLOT_SIZE-1:0] idx_q, idx_d, wpos_q, wpos_d;
  logic [4:0] slots_q, slots_d;
  logic [5:0] slotsize_q, slotsize_d;
  logic [15:0] vpeid_q, vpeid_d;
  logic [31:0] occ_q, occ_d;
  logic [TCU_REG_DATA_SIZE-1:0] buf_q, buf_d;
  logic [TCU_REG_ADDR_SIZE-1:0] base_q, base_d, addr_q, addr_d;
  logic [TCU_REG_DATA_SIZE-1:0] wben_q, wben_d, wdata_q, wdata_d, msgaddr_q, msgaddr_d;
  logic [TCU_ERROR_SIZE-1:0] err_q, err_d;
  logic done_q;
  logic [63:0] w0_in;
  logic [31:0] occ_in, mask_in, one_hot;
  logic [5:0] ss_in, max_q, inc;
  logic [TCU_ERROR_SIZE-1:0] start_err;
  logic [TCU_SLOT_SIZE-1:0] idx_inc;
  logic [15:0] msgs, msgs_inc;
  logic vpe_upd, unused_bits;
  assign w0_in   = rs_epdata_i[63:0];
  assign occ_in  = rs_epdata_i[128 +: 32];
  assign ss_in   = w0_in[TCU_EP_SLOTSIZE_LSB +: 6];
  assign mask_in = slot_mask(max_slot(w0_in[TCU_EP_SLOTS_LSB +: 5]));
  // admission checks are evaluated on the live inputs in the start cycle
  assign start_err = (w0_in[TCU_EP_TYPE_LSB +: 3] != TCU_EP_RECEIVE) ? TCU_ERROR_NO_REP :
                     (64'(rs_msg_size_i) > (64'd1 << ss_in)) ? TCU_ERROR_RECV_OUT_OF_BOUNDS :
                     ((occ_in & mask_in) == mask_in) ? TCU_ERROR_RECV_NO_SPACE : TCU_ERROR_NONE;
  assign max_q    = max_slot(slots_q);
  assign inc      = {1'b0, idx_q} + 6'd1;
  assign idx_inc  = (inc == max_q) ? '0 : inc[TCU_SLOT_SIZE-1:0];
  assign one_hot  = 32'd1 << idx_q;
  assign msgs     = rs_cur_vpe_i[31:16];
  assign msgs_inc = (&msgs) ? msgs : msgs + 16'd1;
  assign vpe_upd  = TCU_ENABLE_VIRT_PES && tcu_features_virt_pes_i && (vpeid_q == rs_cur_vpe_i[15:0]);
  assign unused_bits = ^{w0_in[63:40], w0_in[34:30], rs_epdata_i[191:160]};
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wpos_d     = wpos_q;
    slots_d    = slots_q;
    slotsize_d = slotsize_q;
    vpeid_d    = vpeid_q;
    occ_d      = occ_q;
    buf_d      = buf_q;
    base_d     = base_q;
    addr_d     = addr_q;
    wben_d     = wben_q;
    wdata_d    = wdata_q;
    msgaddr_d  = msgaddr_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: if (rs_start_i) begin
        wpos_d     = w0_in[TCU_EP_WPOS_LSB +: TCU_SLOT_SIZE];
        idx_d      = w0_in[TCU_EP_WPOS_LSB +: TCU_SLOT_SIZE];
        slots_d    = w0_in[TCU_EP_SLOTS_LSB +: 5];
        slotsize_d = ss_in;
        vpeid_d    = w0_in[TCU_EP_VPE_LSB +: 16];
        occ_d      = occ_in;
        buf_d      = rs_epdata_i[127:64];
        base_d     = TCU_REGADDR_EP_START + TCU_REG_ADDR_SIZE'(rs_recvep_i) * TCU_EP_REG_SIZE;
        err_d      = start_err;
        state_d    = (start_err == TCU_ERROR_NONE) ? S_FIND : S_FINISH;
      end
      S_FIND: if (!occ_q[idx_q]) begin
        state_d   = S_WR_EP0;
        addr_d    = base_q;
        wben_d    = TCU_EP_WPOS_MASK;
        wdata_d   = 64'(idx_inc) << TCU_EP_WPOS_LSB;
        msgaddr_d = buf_q + (64'(idx_q) << slotsize_q);
      end else begin
        idx_d   = idx_inc;
        err_d   = (idx_inc == wpos_q) ? TCU_ERROR_CRITICAL : err_q;
        state_d = (idx_inc == wpos_q) ? S_FINISH : S_FIND;
      end
      S_WR_EP0: if (!rs_reg_stall_i) begin
        state_d = S_WR_EP2;
        addr_d  = base_q + 32'h10;
        wben_d  = {one_hot, one_hot};
        wdata_d = {one_hot, one_hot};
      end
      S_WR_EP2: if (!rs_reg_stall_i) begin
        state_d = vpe_upd ? S_WR_VPE : S_FINISH;
        addr_d  = vpe_upd ? TCU_REGADDR_CUR_VPE : addr_q;
        wben_d  = vpe_upd ? TCU_CUR_VPE_MSGS_MASK : wben_q;
        wdata_d = vpe_upd ? {32'd0, msgs_inc, 16'd0} : wdata_q;
      end
      S_WR_VPE: state_d = rs_reg_stall_i ? S_WR_VPE : S_FINISH;
      default:  state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      wpos_q     <= '0;
      slots_q    <= '0;
      slotsize_q <= '0;
      vpeid_q    <= '0;
      occ_q      <= '0;
      buf_q      <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      wben_q     <= '0;
      wdata_q    <= '0;
      msgaddr_q  <= '0;
      err_q      <= TCU_ERROR_NONE;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wpos_q     <= wpos_d;
      slots_q    <= slots_d;
      slotsize_q <= slotsize_d;
      vpeid_q    <= vpeid_d;
      occ_q      <= occ_d;
      buf_q      <= buf_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      wben_q     <= wben_d;
      wdata_q    <= wdata_d;
      msgaddr_q  <= msgaddr_d;
      err_q      <= err_d;
      done_q     <= (state_q == S_FINISH);
    end
  end
  assign rs_reg_en_o    = (state_q == S_WR_EP0) || (state_q == S_WR_EP2) || (state_q == S_WR_VPE);
  assign rs_reg_addr_o  = addr_q;
  assign rs_reg_wben_o  = wben_q;
  assign rs_reg_wdata_o = wdata_q;
  assign rs_active_o    = (state_q != S_IDLE);
  assign rs_msgaddr_o   = msgaddr_q;
  assign rs_done_o      = done_q;
  assign rs_error_o     = err_q;
endmodule

// File: tb/tb_tcu_ctrl_recv_slot.sv
// tb_tcu_ctrl_recv_slot: scoreboard bench for the receive slot allocator
module tb_tcu_ctrl_recv_slot;
  import tcu_ctrl_recv_slot_pkg::*;
  typedef struct { logic [31:0] addr; logic [63:0] wben; logic [63:0] wdata; } wr_t;
  typedef struct { logic [4:0] err; logic [63:0] maddr; int lat; } res_t;
  wr_t wr_q[$];
  res_t res_q[$];
  logic clk = 1'b0, reset_n_i = 1'b1, rs_reg_stall_i = 1'b0, rs_start_i = 1'b0, tcu_features_virt_pes_i = 1'b0;
  logic [6:0] rs_recvep_i = '0;
  logic [191:0] rs_epdata_i = '0;
  logic [15:0] rs_msg_size_i = '0;
  logic [31:0] rs_cur_vpe_i = '0;
  logic rs_reg_en_o, rs_active_o, rs_done_o;
  logic [63:0] rs_reg_wben_o, rs_reg_wdata_o, rs_msgaddr_o;
  logic [31:0] rs_reg_addr_o;
  logic [4:0] rs_error_o;
  int n_chk = 0, n_bad = 0, cyc = 0, start_cyc = 0, stall_left = 0;
  logic [31:0] stall_addr = '0;
  bit got_done = 0;
  tcu_ctrl_recv_slot #(.TCU_ENABLE_VIRT_PES(1'b1)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .rs_reg_en_o(rs_reg_en_o), .rs_reg_wben_o(rs_reg_wben_o), .rs_reg_addr_o(rs_reg_addr_o),
    .rs_reg_wdata_o(rs_reg_wdata_o), .rs_reg_stall_i(rs_reg_stall_i), .rs_start_i(rs_start_i),
    .rs_recvep_i(rs_recvep_i), .rs_epdata_i(rs_epdata_i), .rs_msg_size_i(rs_msg_size_i),
    .rs_cur_vpe_i(rs_cur_vpe_i), .rs_active_o(rs_active_o), .rs_msgaddr_o(rs_msgaddr_o),
    .rs_done_o(rs_done_o), .rs_error_o(rs_error_o), .tcu_features_virt_pes_i(tcu_features_virt_pes_i)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // stalls the register port for stall_left cycles once the targeted write is presented
  always @(posedge clk) begin
    #1;
    if (stall_left > 0 && rs_reg_en_o && rs_reg_addr_o == stall_addr) begin
      rs_reg_stall_i = 1'b1;
      stall_left--;
    end else rs_reg_stall_i = 1'b0;
  end
  always @(negedge clk) begin : mon
    res_t r;
    if (reset_n_i) begin
      if (rs_reg_en_o) begin
        if (wr_q.size() == 0) chk("unexp_wr", 1, 0);
        else begin
          chk("wr_addr", 64'(rs_reg_addr_o), 64'(wr_q[0].addr));
          chk("wr_wben", rs_reg_wben_o, wr_q[0].wben);
          chk("wr_wdata", rs_reg_wdata_o, wr_q[0].wdata);
          if (!rs_reg_stall_i) void'(wr_q.pop_front());
        end
      end
      if (rs_done_o) begin
        if (res_q.size() == 0) chk("unexp_done", 1, 0);
        else begin
          r = res_q.pop_front();
          chk("err", 64'(rs_error_o), 64'(r.err));
          if (r.err == TCU_ERROR_NONE) chk("msgaddr", rs_msgaddr_o, r.maddr);
          chk("latency", 64'(cyc - start_cyc), 64'(r.lat));
          chk("active_at_done", 64'(rs_active_o), 0);
          got_done = 1;
        end
      end
    end
  end
  function automatic logic [63:0] mk_w0(input logic [2:0] t, input logic [15:0] v, input logic [5:0] ss,
                                        input logic [4:0] sl, input logic [4:0] wp);
    return {24'd0, wp, 5'd0, sl, ss, v, t};
  endfunction
  task automatic send(input logic [6:0] ep, input logic [63:0] w0, input logic [63:0] w1, input logic [63:0] w2,
                      input logic [15:0] msz, input logic [31:0] cur, input bit feat, input int stalls);
    res_t r;
    wr_t w;
    logic [5:0] ss;
    logic [4:0] sl, wp;
    logic [31:0] occ, base;
    logic [15:0] m;
    int ms, i;
    bit full;
    ss = w0[24:19]; sl = w0[29:25]; wp = w0[39:35]; occ = w2[31:0];
    ms = (sl > 5) ? 32 : (1 << sl);
    base = 32'h100 + 32'(ep) * 32'd24;
    full = 1;
    for (int k = 0; k < ms; k++) if (!occ[k]) full = 0;
    r.maddr = '0;
    r.lat = 2;
    if (w0[2:0] != 3'd2) r.err = TCU_ERROR_NO_REP;
    else if (64'(msz) > (64'd1 << ss)) r.err = TCU_ERROR_RECV_OUT_OF_BOUNDS;
    else if (full) r.err = TCU_ERROR_RECV_NO_SPACE;
    else begin
      r.err = TCU_ERROR_NONE;
      r.lat = 5 + stalls;
      i = int'(wp);
      for (int g = 0; g < 64 && occ[i]; g++) begin
        i = (i + 1) % ms;
        r.lat++;
      end
      r.maddr = w1 + (64'(i) << ss);
      w.addr = base; w.wben = 64'h1F << 35; w.wdata = 64'((i + 1) % ms) << 35;
      wr_q.push_back(w);
      w.addr = base + 32'h10; w.wben = (64'd1 << i) | (64'd1 << (i + 32)); w.wdata = w.wben;
      wr_q.push_back(w);
      if (feat && w0[18:3] == cur[15:0]) begin
        m = (cur[31:16] == 16'hFFFF) ? 16'hFFFF : cur[31:16] + 16'd1;
        w.addr = 32'h20; w.wben = 64'hFFFF_0000; w.wdata = {32'd0, m, 16'd0};
        wr_q.push_back(w);
        r.lat++;
      end
    end
    res_q.push_back(r);
    @(posedge clk); #1;
    stall_left = stalls; stall_addr = base + 32'h10;
    rs_recvep_i = ep; rs_epdata_i = {w2, w1, w0}; rs_msg_size_i = msz;
    rs_cur_vpe_i = cur; tcu_features_virt_pes_i = feat;
    got_done = 0; start_cyc = cyc; rs_start_i = 1'b1;
    @(posedge clk); #1;
    rs_start_i = 1'b0;
    chk("active", 64'(rs_active_o), 1);
    for (int k = 0; k < 200 && !got_done; k++) @(posedge clk);
    #1;
    chk("done_seen", 64'(got_done), 1);
    chk("err_hold", 64'(rs_error_o), 64'(r.err));
    chk("wr_left", 64'(wr_q.size()), 0);
    wr_q.delete();
    res_q.delete();
  endtask
  initial begin
    int sl, ms, ss, wp;
    #2 reset_n_i = 1'b0;
    #1;
    chk("rst_en", 64'(rs_reg_en_o), 0);
    chk("rst_active", 64'(rs_active_o), 0);
    repeat (2) @(posedge clk);
    #1 reset_n_i = 1'b1;
    chk("rst_wben", rs_reg_wben_o, 0);
    chk("rst_addr", 64'(rs_reg_addr_o), 0);
    chk("rst_wdata", rs_reg_wdata_o, 0);
    chk("rst_msgaddr", rs_msgaddr_o, 0);
    chk("rst_done", 64'(rs_done_o), 0);
    chk("rst_err", 64'(rs_error_o), 64'(TCU_ERROR_NONE));
    send(7'd1, mk_w0(3'd2, 16'd0, 6'd6, 5'd2, 5'd0), 64'h1000, 64'h0, 16'd64, 32'h0, 1'b0, 0);
    send(7'd2, mk_w0(3'd2, 16'd0, 6'd6, 5'd2, 5'd3), 64'h2000, 64'h9, 16'd32, 32'h0, 1'b0, 0);
    send(7'd3, mk_w0(3'd2, 16'd0, 6'd6, 5'd2, 5'd1), 64'h3000, 64'hF, 16'd8, 32'h0, 1'b0, 0);
    send(7'd4, mk_w0(3'd2, 16'd0, 6'd6, 5'd2, 5'd0), 64'h3000, 64'h0, 16'd65, 32'h0, 1'b0, 0);
    send(7'd5, mk_w0(3'd1, 16'd0, 6'd6, 5'd2, 5'd0), 64'h3000, 64'h0, 16'd8, 32'h0, 1'b0, 0);
    send(7'd6, mk_w0(3'd2, 16'd7, 6'd6, 5'd2, 5'd0), 64'h4000, 64'h0, 16'd64, {16'd3, 16'd7}, 1'b1, 0);
    send(7'd6, mk_w0(3'd2, 16'd7, 6'd6, 5'd2, 5'd0), 64'h4000, 64'h0, 16'd64, {16'd3, 16'd8}, 1'b1, 0);
    send(7'd6, mk_w0(3'd2, 16'd7, 6'd6, 5'd2, 5'd0), 64'h4000, 64'h0, 16'd64, {16'hFFFF, 16'd7}, 1'b1, 0);
    send(7'd6, mk_w0(3'd2, 16'd7, 6'd6, 5'd2, 5'd0), 64'h4000, 64'h0, 16'd64, {16'd3, 16'd7}, 1'b0, 0);
    send(7'd9, mk_w0(3'd2, 16'd1, 6'd5, 5'd3, 5'd2), 64'h5000, 64'h4, 16'd20, {16'd9, 16'd1}, 1'b1, 4);
    send(7'd10, mk_w0(3'd2, 16'd0, 6'd6, 5'd7, 5'd31), 64'h6000, 64'h8000_0000, 16'd64, 32'h0, 1'b0, 0);
    for (int n = 0; n < 8; n++) begin
      sl = int'($urandom_range(0, 6));
      ms = (sl > 5) ? 32 : (1 << sl);
      ss = int'($urandom_range(4, 8));
      wp = int'($urandom_range(0, ms - 1));
      send(7'(n + 20), mk_w0(3'd2, 16'(n), 6'(ss), 5'(sl), 5'(wp)), {32'd0, $urandom} << 8,
           {$urandom, $urandom}, 16'($urandom_range(1, 1 << ss)), {16'(n * 3), 16'(n)}, 1'b1, 0);
    end
    @(posedge clk); #1;
    rs_recvep_i = 7'd11;
    rs_epdata_i = {32'd0, 32'h7FFF_FFFF, 64'h7000, mk_w0(3'd2, 16'd0, 6'd6, 5'd5, 5'd0)};
    rs_msg_size_i = 16'd16;
    rs_start_i = 1'b1;
    @(posedge clk); #1;
    rs_start_i = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    chk("mid_active", 64'(rs_active_o), 1);
    reset_n_i = 1'b0;
    #1;
    chk("arst_active", 64'(rs_active_o), 0);
    chk("arst_en", 64'(rs_reg_en_o), 0);
    chk("arst_done", 64'(rs_done_o), 0);
    chk("arst_err", 64'(rs_error_o), 64'(TCU_ERROR_NONE));
    @(posedge clk); #1;
    reset_n_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("post_rst_idle", 64'(rs_active_o), 0);
    send(7'd1, mk_w0(3'd2, 16'd0, 6'd6, 5'd2, 5'd2), 64'h8000, 64'h4, 16'd1, 32'h0, 1'b0, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
